// File: rtl/shift_unit_if.sv
// Handshake and result bundle for shift_unit: start/op/a/amt in, busy/done/result flags out.
interface shift_unit_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [AMT_W-1:0] amt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             carry;
  logic             ovf;
  logic             zero;

  modport master (
    output start, op, a, amt,
    input  busy, done, y, carry, ovf, zero
  );

  modport slave (
    input  start, op, a, amt,
    output busy, done, y, carry, ovf, zero
  );
endinterface

// File: rtl/shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROL unit, one bit position per clock with start/busy/done handshake.
// Define SHIFT_UNIT_ROTATE_EN to enable ROL on op=11; otherwise op=11 acts as SLL.
module shift_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input logic         clk,
  input logic         rst,
  shift_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [AMT_W-1:0] cnt;
  logic [1:0]       op_q;

  logic [WIDTH-1:0] y_nxt;
  logic             carry_nxt;
  logic             ovf_step;

  // Single-step datapath; op=11 falls into the SLL default unless rotate is built in.
  always_comb begin
    y_nxt     = {bus.y[WIDTH-2:0], 1'b0};
    carry_nxt = bus.y[WIDTH-1];
    ovf_step  = bus.y[WIDTH-1] ^ bus.y[WIDTH-2];
    case (op_q)
      2'b01: begin
        y_nxt     = {1'b0, bus.y[WIDTH-1:1]};
        carry_nxt = bus.y[0];
        ovf_step  = 1'b0;
      end
      2'b10: begin
        y_nxt     = {bus.y[WIDTH-1], bus.y[WIDTH-1:1]};
        carry_nxt = bus.y[0];
        ovf_step  = 1'b0;
      end
`ifdef SHIFT_UNIT_ROTATE_EN
      2'b11: begin
        y_nxt     = {bus.y[WIDTH-2:0], bus.y[WIDTH-1]};
        carry_nxt = bus.y[WIDTH-1];
        ovf_step  = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.y     <= '0;
      bus.carry <= 1'b0;
      bus.ovf   <= 1'b0;
      bus.zero  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.y     <= bus.a;
            bus.zero  <= (bus.a == '0);
            bus.carry <= 1'b0;
            bus.ovf   <= 1'b0;
            bus.busy  <= 1'b1;
            cnt       <= bus.amt;
            op_q      <= bus.op;
            if (bus.amt != '0) begin
              state <= SHIFT;
            end else begin
              state    <= DONE;
              bus.done <= 1'b1;
            end
          end
        end
        SHIFT: begin
          bus.y     <= y_nxt;
          bus.zero  <= (y_nxt == '0);
          bus.carry <= carry_nxt;
          bus.ovf   <= bus.ovf | ovf_step;
          cnt       <= cnt - 1'b1;
          if (cnt == AMT_W'(1)) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed cases plus random ops against an arithmetic reference model.
module tb_shift_unit;
  localparam int W  = 8;
  localparam int AW = 3;

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  shift_unit_if #(.WIDTH(W), .AMT_W(AW)) bus_i ();

  shift_unit #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-operation result computed with wide integer arithmetic.
  task automatic model(input logic [1:0] o, input logic [W-1:0] av, input logic [AW-1:0] n_in,
                       output logic [W-1:0] ey, output logic ec, output logic eo);
    longint ua, sa, p, sp;
    int     n, md, r;
    n  = int'(n_in);
    ua = longint'(av);
    sa = av[W-1] ? ua - (longint'(1) << W) : ua;
    md = int'(o);
`ifndef SHIFT_UNIT_ROTATE_EN
    if (md == 3) md = 0;
`endif
    ey = '0; ec = 1'b0; eo = 1'b0;
    case (md)
      0: begin
        p  = ua << n;
        ey = p[W-1:0];
        ec = p[W];
        sp = sa * (longint'(1) << n);
        eo = (sp > (longint'(1) << (W-1)) - 1) || (sp < -(longint'(1) << (W-1)));
      end
      1: begin
        p  = ua >> n;
        ey = p[W-1:0];
        if (n != 0) begin p = ua >> (n-1); ec = p[0]; end
      end
      2: begin
        p  = sa >>> n;
        ey = p[W-1:0];
        if (n != 0) begin p = sa >>> (n-1); ec = p[0]; end
      end
      default: begin
        r  = n % W;
        p  = (ua << r) | (ua >> (W-r));
        ey = p[W-1:0];
        ec = (n != 0) ? ey[0] : 1'b0;
      end
    endcase
  endtask

  // Called at a negedge with the DUT idle; leaves at the negedge of the cycle after done.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [AW-1:0] n_in,
                        input bit poke);
    logic [W-1:0] ey;
    logic         ec, eo;
    int           n;
    n = int'(n_in);
    model(o, av, n_in, ey, ec, eo);
    bus_i.start = 1'b1; bus_i.op = o; bus_i.a = av; bus_i.amt = n_in;
    @(posedge clk);
    #1 bus_i.start = 1'b0;
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      chk("busy_window", bus_i.busy, 1);
      chk("done_timing", bus_i.done, (c == n + 1) ? 1 : 0);
      if (poke && c == 1) begin
        bus_i.start = 1'b1; bus_i.a = ~av; bus_i.op = o ^ 2'b01; bus_i.amt = 3'd1;
      end else begin
        bus_i.start = 1'b0;
      end
    end
    chk("y", bus_i.y, ey);
    chk("carry", bus_i.carry, ec);
    chk("ovf", bus_i.ovf, eo);
    chk("zero", bus_i.zero, (ey == '0) ? 1 : 0);
    @(negedge clk);
    chk("idle_busy", bus_i.busy, 0);
    chk("idle_done", bus_i.done, 0);
    chk("hold_y", bus_i.y, ey);
    chk("hold_carry", bus_i.carry, ec);
  endtask

  initial begin
    rst = 1'b1;
    bus_i.start = 1'b0; bus_i.op = 2'b00; bus_i.a = '0; bus_i.amt = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus_i.busy, 0);
    chk("rst_done", bus_i.done, 0);
    chk("rst_y", bus_i.y, 0);
    chk("rst_carry", bus_i.carry, 0);
    chk("rst_ovf", bus_i.ovf, 0);
    chk("rst_zero", bus_i.zero, 1);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'b00, 8'h81, 3'd1, 1'b0);
    run_op(2'b10, 8'h80, 3'd3, 1'b0);
    run_op(2'b01, 8'h80, 3'd3, 1'b0);
    run_op(2'b11, 8'h81, 3'd1, 1'b0);
    for (int o = 0; o < 4; o++) run_op(2'(o), 8'h00, 3'd0, 1'b0);
    run_op(2'b00, 8'h01, 3'd7, 1'b0);
    run_op(2'b10, 8'hC3, 3'd7, 1'b0);
    run_op(2'b11, 8'hA5, 3'd7, 1'b0);
    run_op(2'b00, 8'h3C, 3'd5, 1'b1);
    run_op(2'b01, 8'h5A, 3'd2, 1'b0);

    // Reset during the second shift cycle of an amt=5 SLL.
    bus_i.start = 1'b1; bus_i.op = 2'b00; bus_i.a = 8'h5A; bus_i.amt = 3'd5;
    @(posedge clk);
    #1 bus_i.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", bus_i.busy, 0);
    chk("abort_done", bus_i.done, 0);
    chk("abort_y", bus_i.y, 0);
    chk("abort_zero", bus_i.zero, 1);
    chk("abort_carry", bus_i.carry, 0);
    chk("abort_ovf", bus_i.ovf, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_done", bus_i.done, 0);
    end

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), 8'($urandom), 3'($urandom_range(0, 7)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
